// File: rtl/sub_bytes_shift_rows.sv
// sub_bytes_shift_rows: iterative AES SubBytes + ShiftRows stage feeding mixColumns
// Ports: clk/rst_n (async active-low reset); in_valid/in_ready/input_s accept one 128-bit state;
// out_valid/out_ready/output_s hand the substituted, row-shifted state downstream; busy while SUB or DONE.
// Byte b = 4*col + row lives at bits [8*b +: 8].
module sub_bytes_shift_rows #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] input_s,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] output_s,
    output logic         busy
);
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end
    // Entry 0 sits in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
    state_t       state, state_nx;
    logic [1:0]   col;
    logic [127:0] work, work_sub, shifted;
    logic         last_grp;
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[8*(255 - int'(x)) +: 8];
    endfunction
    assign last_grp = col == LAST_COL;
    // col is always a multiple of COLS_PER_CYCLE, so col+g never runs past column 3.
    always_comb begin
        work_sub = work;
        for (int g = 0; g < COLS_PER_CYCLE; g++)
            for (int r = 0; r < 4; r++)
                work_sub[8*(4*(int'(col) + g) + r) +: 8] = sbox(work[8*(4*(int'(col) + g) + r) +: 8]);
    end
    // ShiftRows taken from work_sub so the final group lands in output_s on the same edge.
    always_comb begin
        shifted = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                shifted[8*(4*c + r) +: 8] = work_sub[8*(4*((c + r) % 4) + r) +: 8];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? SUB : IDLE;
            SUB:     state_nx = last_grp ? DONE : SUB;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        in_ready = state == IDLE;
        busy     = state != IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            work      <= '0;
            output_s  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                work <= input_s;
                col  <= '0;
            end
            if (state == SUB) begin
                work <= work_sub;
                col  <= col + COL_STEP;
            end
            if (state == SUB && last_grp) begin
                output_s  <= shifted;
                out_valid <= 1'b1;
            end
            if (state == DONE && out_ready) out_valid <= 1'b0;
        end
    end
endmodule
